// File: rtl/sort_frame_ctrl_pkg.sv
// Shared definitions for the sort frame controller: frame size, fill-side states, pad value.
// Pure declarations; no latency or flow-control behaviour of its own.
package sort_frame_ctrl_pkg;

  localparam int FRAME = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SORT1 = 2'd1,
    ST_SORT2 = 2'd2
  } state_t;

endpackage

// Largest positive two's-complement value of width W; sorts to the top so pads stay out of the drained prefix.
`define SFC_PAD_VAL(W) {1'b0, {((W)-1){1'b1}}}

// File: rtl/two_stages_bitonic_sorter.sv
// 8-input ascending bitonic sorter, 3 compare layers before and 3 after one register stage (latency 1).
// Free-running: no handshake, the register reloads every cycle.
module two_stages_bitonic_sorter
  import sort_frame_ctrl_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [N-1:0] e,
  input  logic [N-1:0] f,
  input  logic [N-1:0] g,
  input  logic [N-1:0] h,
  output logic [N-1:0] i,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic [N-1:0] l,
  output logic [N-1:0] m,
  output logic [N-1:0] n,
  output logic [N-1:0] o,
  output logic [N-1:0] p
);

  typedef logic [FRAME-1:0][N-1:0] vec_t;

  function automatic vec_t ce(input vec_t v, input int lo, input int hi, input logic up);
    vec_t r;
    logic swap;
    r    = v;
    swap = up ? ($signed(v[lo]) > $signed(v[hi])) : ($signed(v[lo]) < $signed(v[hi]));
    if (swap) begin
      r[lo] = v[hi];
      r[hi] = v[lo];
    end
    return r;
  endfunction

  vec_t stage_a;
  vec_t mid_q;
  vec_t stage_b;

  // Build two bitonic halves: 0..3 ascending, 4..7 descending.
  always_comb begin
    stage_a = {h, g, f, e, d, c, b, a};
    stage_a = ce(stage_a, 0, 1, 1'b1);
    stage_a = ce(stage_a, 2, 3, 1'b0);
    stage_a = ce(stage_a, 4, 5, 1'b1);
    stage_a = ce(stage_a, 6, 7, 1'b0);
    stage_a = ce(stage_a, 0, 2, 1'b1);
    stage_a = ce(stage_a, 1, 3, 1'b1);
    stage_a = ce(stage_a, 4, 6, 1'b0);
    stage_a = ce(stage_a, 5, 7, 1'b0);
    stage_a = ce(stage_a, 0, 1, 1'b1);
    stage_a = ce(stage_a, 2, 3, 1'b1);
    stage_a = ce(stage_a, 4, 5, 1'b0);
    stage_a = ce(stage_a, 6, 7, 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mid_q <= '0;
    else        mid_q <= stage_a;
  end

  // Final ascending bitonic merge across all 8 lanes.
  always_comb begin
    stage_b = mid_q;
    stage_b = ce(stage_b, 0, 4, 1'b1);
    stage_b = ce(stage_b, 1, 5, 1'b1);
    stage_b = ce(stage_b, 2, 6, 1'b1);
    stage_b = ce(stage_b, 3, 7, 1'b1);
    stage_b = ce(stage_b, 0, 2, 1'b1);
    stage_b = ce(stage_b, 1, 3, 1'b1);
    stage_b = ce(stage_b, 4, 6, 1'b1);
    stage_b = ce(stage_b, 5, 7, 1'b1);
    stage_b = ce(stage_b, 0, 1, 1'b1);
    stage_b = ce(stage_b, 2, 3, 1'b1);
    stage_b = ce(stage_b, 4, 5, 1'b1);
    stage_b = ce(stage_b, 6, 7, 1'b1);
  end

  assign {p, o, n, m, l, k, j, i} = stage_b;

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frames up to 8 signed samples, sorts them ascending; first out_valid 3 cycles after the closing input beat.
// in_ready drops during SORT1/SORT2; a full output buffer stalls the fill side in SORT2.
module sort_frame_ctrl
  import sort_frame_ctrl_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  typedef logic [FRAME-1:0][N-1:0] buf_t;

  state_t     state_q, state_d;
  logic [2:0] wr_idx_q, wr_idx_d;
  logic [3:0] len_q, len_d;
  logic [3:0] out_len_q, out_len_d;
  logic       out_full_q, out_full_d;
  logic [2:0] rd_idx_q, rd_idx_d;
  buf_t       fill_buf_q, fill_buf_d;
  buf_t       out_buf_q, out_buf_d;
  buf_t       sorted;

  two_stages_bitonic_sorter #(.N(N)) u_sorter (
    .clk   (clk),
    .rst_n (~rst),
    .a     (fill_buf_q[0]),
    .b     (fill_buf_q[1]),
    .c     (fill_buf_q[2]),
    .d     (fill_buf_q[3]),
    .e     (fill_buf_q[4]),
    .f     (fill_buf_q[5]),
    .g     (fill_buf_q[6]),
    .h     (fill_buf_q[7]),
    .i     (sorted[0]),
    .j     (sorted[1]),
    .k     (sorted[2]),
    .l     (sorted[3]),
    .m     (sorted[4]),
    .n     (sorted[5]),
    .o     (sorted[6]),
    .p     (sorted[7])
  );

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = out_full_q;
  assign out_data  = out_buf_q[rd_idx_q];
  assign out_last  = out_full_q && ({1'b0, rd_idx_q} == (out_len_q - 4'd1));
  assign busy      = (state_q != ST_FILL) || out_full_q;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    len_d      = len_q;
    out_len_d  = out_len_q;
    out_full_d = out_full_q;
    rd_idx_d   = rd_idx_q;
    fill_buf_d = fill_buf_q;
    out_buf_d  = out_buf_q;

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          fill_buf_d[wr_idx_q] = in_data;
          wr_idx_d             = wr_idx_q + 3'd1;
          if (in_last || (wr_idx_q == 3'd7)) begin
            len_d   = {1'b0, wr_idx_q} + 4'd1;
            state_d = ST_SORT1;
            for (int s = 0; s < FRAME; s++) begin
              if (3'(s) > wr_idx_q) fill_buf_d[s] = `SFC_PAD_VAL(N);
            end
          end
        end
      end
      ST_SORT1: state_d = ST_SORT2;
      ST_SORT2: begin
        // Capture only into an empty buffer; fill_buf is stable so the sorter keeps re-presenting the result.
        if (!out_full_q) begin
          out_buf_d  = sorted;
          out_len_d  = len_q;
          out_full_d = 1'b1;
          wr_idx_d   = 3'd0;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (out_full_q && out_ready) begin
      if (out_last) begin
        out_full_d = 1'b0;
        rd_idx_d   = 3'd0;
      end else begin
        rd_idx_d = rd_idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      wr_idx_q   <= '0;
      len_q      <= '0;
      out_len_q  <= '0;
      out_full_q <= 1'b0;
      rd_idx_q   <= '0;
      fill_buf_q <= '0;
      out_buf_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      len_q      <= len_d;
      out_len_q  <= out_len_d;
      out_full_q <= out_full_d;
      rd_idx_q   <= rd_idx_d;
      fill_buf_q <= fill_buf_d;
      out_buf_q  <= out_buf_d;
    end
  end

endmodule

// File: doc/sort_frame_ctrl.md
# sort_frame_ctrl

Streaming frame controller for the 8-input, 2-stage pipelined bitonic sorter (`two_stages_bitonic_sorter`). It collects up to 8 signed samples from a valid/ready input stream into a fill buffer, pads short frames, and sequences the sorter through its one register stage. It captures the ascending result into an output buffer and drains it as a valid/ready stream. Fill of frame k+1 overlaps drain of frame k.

## Interface
- `N`, default 7: sample width, two's complement; passed to the sorter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high; sorter gets `rst_n = ~rst`.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  controller can accept a sample.
- `in_data`  in  N  signed sample.
- `in_last`  in  1  last sample of frame; qualified by `in_valid`.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  N  signed sorted sample, ascending.
- `out_last`  out  1  final sample of the frame.
- `busy`  out  1  fill side not in FILL, or output buffer occupied.

## Operation
- Transfer rule: a beat occurs on a rising edge with valid && ready. Valid and data hold until the beat.
- Fill-side FSM: FILL, SORT1, SORT2.
  - FILL: `in_ready`=1. Each beat writes `fill_buf[wr_idx]` and increments `wr_idx` (3 bits). If the beat has `in_last`, or `wr_idx`==7, latch `len = wr_idx+1` (4 bits, 1..8) and go to SORT1.
  - FILL exit: slots `len..7` are loaded with the pad value 2^(N-1)-1 (max positive) on the same edge.
  - SORT1: `in_ready`=0. One cycle; the sorter's register loads the complete `fill_buf`. Go to SORT2.
  - SORT2: `in_ready`=0. The sorter outputs i..p are valid. If the output buffer is empty, capture i..p into `out_buf[0..7]` and `len` into `out_len`, reset `wr_idx`=0, and go to FILL. Otherwise hold in SORT2.
  - Holding in SORT2 is safe: `fill_buf` is stable, so the sorter reloads identical data.
- `fill_buf` drives sorter inputs a..h directly (slot 0 to a ... slot 7 to h).
- Output side: `out_full` flag and `rd_idx` (3 bits).
  - `out_valid = out_full`; `out_data = out_buf[rd_idx]`; `out_last = out_full && (rd_idx == out_len-1)`.
  - Each output beat increments `rd_idx`. A beat with `out_last` clears `out_full` and `rd_idx`.
  - Capture in SORT2 requires `out_full`=0 at the start of the cycle. No same-cycle drain/refill bypass; one bubble cycle occurs between frames when stalled.
- Padding values never appear on the output: only `out_len` samples are drained. A real sample equal to 2^(N-1)-1 sorts identically to a pad, so the result is unchanged.
- A frame longer than 8 without `in_last` is split: the 8th sample closes the frame. The next sample starts a new frame.
- Reset (asynchronous, any state, including mid-fill or mid-drain):
  - State goes to FILL; `wr_idx`, `rd_idx`, `len`, `out_len`, `out_full` clear to 0.
  - The partial frame is discarded; buffers are cleared to 0.
  - Output values in reset: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.
  - `in_ready` is 1 throughout reset so the FILL state is visible immediately; no beat is taken while `rst`=1.

## Timing
- Let E0 be the edge of the closing input beat. SORT1 is the cycle after E0, SORT2 the next. The capture edge ends SORT2, and `out_valid` rises in the 3rd cycle after E0.
- `in_ready` returns to 1 in the cycle after the capture edge.
- Throughput with `out_ready` held at 1: an 8-sample frame takes 8 fill + 2 sort cycles. Drain (8 cycles) overlaps the next fill, so the sustained rate is 8 samples per 10 cycles.
- Combinational paths: `out_data`/`out_last` come from registers through the `rd_idx` mux only. `in_ready`/`out_valid` are register-decoded. No combinational path from `out_ready` to `in_ready`.

## Structure
- Shared package/header: FSM state encodings (FILL=0, SORT1=1, SORT2=2), `FRAME=8`, and a pad-value macro derived from `N`.
- One sub-module: `two_stages_bitonic_sorter #(.N(N))`, instantiated once.
- Everything else (both buffers, indices, FSM) lives in `sort_frame_ctrl`.

## Test plan
- Full frame: input 3,-1,7,0,-64,63,2,-5 with `in_last` on the 8th, `out_ready`=1. Output is -64,-5,-1,0,2,3,7,63 with `out_last` on 63; first `out_valid` in the 3rd cycle after the last input beat.
- Short frame: input 5,-2,9 with `in_last`. Output -2,5,9, `out_last` on 9; no pad value (63) is emitted.
- Pad tie: input 63,-3 with `in_last`. Output -3,63 with `out_last` on 63.
- Backpressure: `out_ready`=0 while two full frames arrive. The second frame holds in SORT2 with `in_ready`=0. Releasing `out_ready` drains frame 1 completely, then frame 2, in order with no loss.
- Overlong frame: 10 samples 10..1 with `in_last` only on the 10th. Outputs are 3..10 (`out_last` on 10), then 1,2 (`out_last` on 2).
- Reset mid-operation: assert `rst` after 4 input beats, or mid-drain. Outputs immediately go `out_valid`=0, `in_ready`=1. A fresh frame afterwards sorts correctly with no stale data.
